muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a reset; reset SHALL be synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  EX-stage request; sampled only in IDLE.
REQ-005 Port: aluctl  input  4  low nibble of the 9-bit ALU control word; 4'b1000 = mult, 4'b1001 = div.
REQ-006 Port: a  input  32  rs operand (multiplicand / dividend), two's complement.
REQ-007 Port: b  input  32  rt operand (multiplier / divisor), two's complement.
REQ-008 Port: cancel  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 Port: busy  output  1  stall request to the hazard unit while an operation is in flight.
REQ-010 Port: done  output  1  one-cycle pulse; new HI/LO are visible in the same cycle.
REQ-011 Port: dz  output  1  divide-by-zero flag; valid only while done=1.
REQ-012 Port: hi  output  32  HI register, read by mfhi.
REQ-013 Port: lo  output  32  LO register, read by mflo.

Function
REQ-014 States SHALL be IDLE, RUN and FIN.
REQ-015 IDLE->RUN SHALL occur when start=1, cancel=0 and aluctl is 4'b1000 or 4'b1001.
REQ-016 start with any other aluctl SHALL be ignored.
REQ-017 On the accepting edge, operand magnitudes, result signs and op type SHALL be latched, and the 6-bit iteration counter SHALL load 31.
REQ-018 RUN SHALL perform one radix-2 step per cycle for exactly 32 cycles: shift-add for mult, restoring subtract for div.
REQ-019 RUN->FIN SHALL occur on the edge where the counter equals 0.
REQ-020 FIN SHALL last one cycle and apply sign correction to the results.
REQ-021 On the edge leaving FIN, hi/lo SHALL be written, done and dz SHALL be registered, and the state SHALL return to IDLE.
REQ-022 busy SHALL be 1 exactly in RUN and FIN, i.e. 33 cycles after the accepting edge.
REQ-023 done SHALL be 1 in the cycle immediately after busy falls.
REQ-024 A new start SHALL be accepted in the done cycle itself (back-to-back).
REQ-025 mult: {hi,lo} SHALL equal the signed 64-bit product of a and b.
REQ-026 div: lo SHALL be the quotient truncated toward zero, and hi SHALL be the remainder carrying the sign of the dividend.
REQ-027 div with -2^31 / -1 SHALL give lo=32'h80000000, hi=0 (wraparound), with dz=0.
REQ-028 div with b=0 SHALL keep the full 34-cycle latency, give hi=a and lo=32'hFFFFFFFF, and set dz=1 with done.
REQ-029 start while busy=1 SHALL be ignored; no queuing.
REQ-030 cancel=1 in RUN or FIN SHALL return the state to IDLE on the next edge, with no hi/lo write and no done.
REQ-031 cancel and start together in IDLE: cancel SHALL win and the request is dropped.
REQ-032 hi/lo SHALL change only on a FIN exit or on reset.

Reset
REQ-033 On reset: state=IDLE, counter=0, busy=0, done=0, dz=0, hi=0, lo=0, and all internal accumulators=0.
REQ-034 Reset SHALL take priority over cancel and start.
REQ-035 Reset mid-operation SHALL discard the operation without producing done.

Structure
REQ-036 Op codes 4'b1000/4'b1001, data width 32 and the iteration count 32 SHALL be placed in the shared CPU definitions package, next to the other ALU control codes.
REQ-037 The state encoding SHALL be local to muldiv_unit.
REQ-038 A single sub-module, muldiv_iter, SHALL hold the unsigned 64-bit shift/accumulate datapath and one step per enable.
REQ-039 muldiv_unit SHALL hold the FSM, sign handling and the HI/LO registers.

Verification
REQ-040 mult a=7, b=32'hFFFFFFFD (-3) -> busy for 33 cycles, then done with hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-041 mult a=b=32'h80000000 -> hi=32'h40000000, lo=0.
REQ-042 div a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, dz=0; then a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-043 div a=5, b=0 -> done 34 cycles after start, hi=5, lo=32'hFFFFFFFF, dz=1.
REQ-044 mult 3*4 started, then start pulsed at cycle 5 and cancel at cycle 10 -> busy=0 at cycle 11, hi/lo keep their prior values, done never asserts.
REQ-045 Back-to-back mult 3*4 then div 12/5 issued in the done cycle -> first result hi=0, lo=12; second result lo=2, hi=2; reset at cycle 20 of the second op -> all outputs 0, no done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module : muldiv_unit_pkg
// Brief  : Shared CPU definitions: ALU control codes, data width, iteration count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  localparam int c_XLEN  = 32;
  localparam int c_ITERS = 32;
  localparam int c_CNT_W = 6;

  // Low nibble of the 9-bit ALU control word
  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_MULT = 4'b1000;
  localparam logic [3:0] c_ALU_DIV  = 4'b1001;

  function automatic logic [c_XLEN-1:0] mag(input logic [c_XLEN-1:0] v);
    return v[c_XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module : muldiv_iter
// Brief  : Unsigned 64-bit radix-2 shift-add / restoring-divide datapath, one step per enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter
  import muldiv_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic                  is_div_i,
  input  logic [c_XLEN-1:0]     init_i,
  input  logic [c_XLEN-1:0]     opnd_i,
  output logic [2*c_XLEN-1:0]   acc_o
);

  localparam int W = c_XLEN;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q;
  logic [W:0]     w_sum;
  logic [W:0]     w_rem_sh;
  logic [W:0]     w_diff;
  logic           w_ge;

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    w_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    w_rem_sh = acc_q[2*W-1:W-1];
    w_ge     = (w_rem_sh >= {1'b0, opnd_q});
    w_diff   = w_rem_sh - {1'b0, opnd_q};
    acc_d    = acc_q;
    if (is_div_i) begin
      if (w_ge) acc_d = {w_diff[W-1:0], acc_q[W-2:0], 1'b1};
      else      acc_d = {w_rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      acc_d = {w_sum, acc_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= {{W{1'b0}}, init_i};
      opnd_q <= opnd_i;
    end else if (en_i) begin
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Multi-cycle signed mult/div unit with FSM, sign handling and HI/LO registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        aluctl,
  input  logic [c_XLEN-1:0] a,
  input  logic [c_XLEN-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic              dz,
  output logic [c_XLEN-1:0] hi,
  output logic [c_XLEN-1:0] lo
);

  localparam int W = c_XLEN;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, neg_q, neg_rem_q, dz_pend_q;
  logic [W-1:0]     hi_q, lo_q;
  logic             done_q, dz_q;

  logic             w_accept, w_step;
  logic [2*W-1:0]   w_acc, w_prod;
  logic [W-1:0]     w_quo, w_rem, w_hi_fin, w_lo_fin;

  assign w_accept = (state_q == c_IDLE) && start && !cancel &&
                    ((aluctl == c_ALU_MULT) || (aluctl == c_ALU_DIV));
  assign w_step   = (state_q == c_RUN) && !cancel;

  muldiv_iter u_iter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_accept),
    .en_i     (w_step),
    .is_div_i (is_div_q),
    .init_i   (mag(a)),
    .opnd_i   (mag(b)),
    .acc_o    (w_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: if (w_accept) begin
        state_d = c_RUN;
        cnt_d   = c_CNT_W'(c_ITERS - 1);
      end
      c_RUN: begin
        if (cancel)           state_d = c_IDLE;
        else if (cnt_q == '0) state_d = c_FIN;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      c_FIN:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Sign correction applied during FIN; divide-by-zero forces an all-ones quotient
  always_comb begin
    w_prod = neg_q ? (~w_acc + 1'b1) : w_acc;
    w_quo  = neg_q ? (~w_acc[W-1:0] + 1'b1) : w_acc[W-1:0];
    w_rem  = neg_rem_q ? (~w_acc[2*W-1:W] + 1'b1) : w_acc[2*W-1:W];
    if (is_div_q) begin
      w_hi_fin = w_rem;
      w_lo_fin = dz_pend_q ? {W{1'b1}} : w_quo;
    end else begin
      w_hi_fin = w_prod[2*W-1:W];
      w_lo_fin = w_prod[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      if (w_accept) begin
        is_div_q  <= (aluctl == c_ALU_DIV);
        neg_q     <= a[W-1] ^ b[W-1];
        neg_rem_q <= a[W-1];
        dz_pend_q <= (aluctl == c_ALU_DIV) && (b == '0);
      end
      if ((state_q == c_FIN) && !cancel) begin
        hi_q   <= w_hi_fin;
        lo_q   <= w_lo_fin;
        done_q <= 1'b1;
        dz_q   <= dz_pend_q;
      end
    end
  end

  assign busy = (state_q == c_RUN) || (state_q == c_FIN);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Self-checking bench for muldiv_unit: directed vectors, random ops, cancel/reset cases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  aluctl;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluctl (aluctl),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .dz     (dz),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers
  function automatic void model(input logic [3:0] ctl, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sa, sb, p, q, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ez = 1'b0;
    if (ctl == OP_MULT) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (mb == 32'd0) begin
      eh = ma;
      el = 32'hFFFF_FFFF;
      ez = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Issue one op from IDLE (or the done cycle) and check latency and result
  task automatic do_op(input string nm, input logic [3:0] ctl, input logic [31:0] oa, input logic [31:0] ob,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int nb;
    start = 1'b1; aluctl = ctl; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      @(posedge clk); #1;
      nb++;
    end
    chk({nm, "_busy_cycles"}, 64'(nb), 64'd33);
    chk({nm, "_done"}, {63'd0, done}, 64'd1);
    chk({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
    chk({nm, "_dz"}, {63'd0, dz}, {63'd0, ez});
  endtask

  initial begin
    logic [31:0] eh, el, phi, plo;
    logic        ez, seen;
    logic [3:0]  rc;
    logic [31:0] ra, rb;

    vecs[0] = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{OP_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{OP_DIV,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{OP_MULT, 32'd3,          32'd4,         32'd0,         32'd12,        1'b0};
    vecs[6] = '{OP_DIV,  32'd12,         32'd5,         32'd2,         32'd2,         1'b0};
    vecs[7] = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; aluctl = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz",   {63'd0, dz},   64'd0);
    chk("rst_hilo", {hi, lo},      64'd0);
    reset = 1'b0;

    // Unsupported op code is ignored
    start = 1'b1; aluctl = 4'b0010; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_aluctl_busy", {63'd0, busy}, 64'd0);

    // cancel beats start in IDLE
    start = 1'b1; cancel = 1'b1; aluctl = OP_MULT;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", {63'd0, busy}, 64'd0);

    // Directed vectors, issued back-to-back in each done cycle
    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].va, vecs[i].vb,
            vecs[i].ehi, vecs[i].elo, vecs[i].edz);

    // Cancel mid-flight; start pulsed while busy must be ignored
    phi = hi; plo = lo;
    start = 1'b1; aluctl = OP_MULT; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; aluctl = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy_after", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("cancel_no_done", {63'd0, seen}, 64'd0);
    chk("cancel_hilo_kept", {hi, lo}, {phi, plo});

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'd0 - 32'($urandom_range(1, 9));
        2: ra = 32'($urandom_range(0, 100));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      model(rc, ra, rb, eh, el, ez);
      do_op($sformatf("rnd%0d", i), rc, ra, rb, eh, el, ez);
    end

    // Back-to-back then reset during the second op
    do_op("b2b_mult", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    start = 1'b1; aluctl = OP_DIV; a = 32'd12; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_dz",   {63'd0, dz},   64'd0);
    chk("midreset_hilo", {hi, lo},      64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midreset_no_done", {63'd0, seen}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
